coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front end of the vending datapath, directly upstream of the vending FSM.
//  Conditions the three raw coin inputs (quarter, half dollar, dollar): synchronise, debounce, edge-detect.
//  Emits exactly one coin event per physical insertion as a 2-bit coin code with a valid/ready handshake.
//  Replaces the manual key-clock stepping: the FSM advances only on an accepted coin event.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  input must be stable this many CLK cycles to count (20 ms @ 50 MHz)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, not overridden)
// PORTS
//  CLK            in   1  system clock, 50 MHz; single clock domain
//  RES            in   1  asynchronous, active-low reset
//  quarter_in     in   1  raw coin input, active-high, asynchronous to CLK
//  halfDollar_in  in   1  raw coin input, active-high, asynchronous to CLK
//  dollar_in      in   1  raw coin input, active-high, asynchronous to CLK
//  coin_ready     in   1  FSM accepts coin_code this cycle when high
//  coin_code      out  2  coin_t: 00 NONE, 01 QUARTER, 10 HALF, 11 DOLLAR
//  coin_valid     out  1  coin_code holds a pending event
//  coin_reject    out  1  one-cycle pulse: several coins pressed together; no event produced
//  busy           out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (RES low, async): coin_code=NONE, coin_valid=0, coin_reject=0, busy=0, state=IDLE,
//   sync flops=0, debounce counters=0, stable levels=0. Reset mid-handshake drops the pending coin.
//  Per channel: 2-FF synchroniser -> debouncer. The stable level updates only after the synchronised
//   input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
//   Counter saturates; it never wraps.
//  rise[i] = 1-cycle pulse when stable level i goes 0->1.
//  FSM states: IDLE, HOLD, RELEASE.
//   IDLE: exactly one rise -> register code, coin_valid=1, go HOLD (valid 1 cycle after rise).
//         two or more rises in the same cycle -> coin_reject=1 for 1 cycle, go RELEASE.
//         no rise -> stay.
//   HOLD: coin_valid and coin_code held stable until coin_ready=1. The handshake completes
//         on the cycle where valid&&ready. Next cycle: coin_valid=0, coin_code=NONE, go RELEASE.
//         Rises on other channels while in HOLD are ignored (not queued).
//   RELEASE: wait until all three stable levels are 0, then go IDLE. Holding a coin down never
//         repeats an event.
//  coin_ready while coin_valid=0 is ignored. coin_valid never drops without a handshake except on reset.
//  Latency from a clean raw edge to coin_valid: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  All outputs are registered. No combinational path from the inputs to the outputs.
// STRUCTURE
//  vend_pkg: typedef enum logic [1:0] coin_t {NONE, QUARTER, HALF, DOLLAR};
//   typedef enum acceptor state_t; shared by coin_acceptor and the vending FSM.
//  Sub-module coin_debounce (param DEBOUNCE_CYCLES; ports CLK, RES, raw, stable, rise), instanced
//   3 times. The top holds the FSM and output registers only.
// TESTING (bench overrides DEBOUNCE_CYCLES=8)
//  1. Clean quarter pulse of 20 cycles, coin_ready tied 1 -> coin_valid high exactly 1 cycle,
//     code=01, 11 cycles after the edge.
//  2. Dollar pressed, coin_ready held 0 for 50 cycles, then 1 -> valid/code=11 stable
//     throughout; one transfer only.
//  3. halfDollar_in bouncing (toggles every 3 cycles for 30 cycles), then steady 1 ->
//     exactly one event, code=10.
//  4. Quarter and dollar rising on the same cycle -> coin_reject one pulse, no coin_valid;
//     after both release, a later half dollar gives code=10.
//  5. Quarter held 100 cycles; half dollar pressed during HOLD -> single quarter event;
//     half ignored; IDLE only after both released.
//  6. RES asserted while in HOLD -> outputs clear immediately (async); after release,
//     a new press is accepted normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending datapath: coin codes, acceptor states and
// helpers that classify the per-channel rise vector.
package vend_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        QUARTER = 2'b01,
        HALF    = 2'b10,
        DOLLAR  = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam int unsigned N_COINS = 3;

    // Bit order of the rise vector: [0] quarter, [1] half dollar, [2] dollar.
    function automatic coin_t rise_to_coin(input logic [N_COINS-1:0] rise);
        coin_t code;
        case (rise)
            3'b001:  code = QUARTER;
            3'b010:  code = HALF;
            3'b100:  code = DOLLAR;
            default: code = NONE;
        endcase
        return code;
    endfunction

    function automatic logic multi_rise(input logic [N_COINS-1:0] rise);
        return (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-FF synchroniser, saturating debounce counter and a
// registered rising-edge pulse of the debounced level.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RES,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchroniser for the asynchronous coin input.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Stable level follows the synchronised input only after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r  <= '0;
            rise_r <= 1'b0;
        end else if (cnt_r >= CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
            rise_r   <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            rise_r <= 1'b0;
        end
    end

    assign stable = stable_r;
    assign rise   = rise_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: three debounced channels feeding a one-event-per-insertion
// FSM with a valid/ready handshake towards the vending FSM.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic  CLK,
    input  logic  RES,
    input  logic  quarter_in,
    input  logic  halfDollar_in,
    input  logic  dollar_in,
    input  logic  coin_ready,
    output coin_t coin_code,
    output logic  coin_valid,
    output logic  coin_reject,
    output logic  busy
);

    logic [N_COINS-1:0] raw_s;
    logic [N_COINS-1:0] stable_s;
    logic [N_COINS-1:0] rise_s;

    state_t state_r, state_next_s;
    coin_t  code_r, code_next_s;
    logic   valid_r, valid_next_s;
    logic   reject_r, reject_next_s;
    logic   busy_r;

    assign raw_s = {dollar_in, halfDollar_in, quarter_in};

    for (genvar i = 0; i < N_COINS; i++) begin : g_chan
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK   (CLK),
            .RES   (RES),
            .raw   (raw_s[i]),
            .stable(stable_s[i]),
            .rise  (rise_s[i])
        );
    end

    // Next-state and next-output logic; rises outside IDLE are dropped.
    always_comb begin
        state_next_s  = state_r;
        code_next_s   = code_r;
        valid_next_s  = valid_r;
        reject_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (multi_rise(rise_s)) begin
                    reject_next_s = 1'b1;
                    state_next_s  = RELEASE;
                end else if (rise_s != 3'b000) begin
                    code_next_s  = rise_to_coin(rise_s);
                    valid_next_s = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    code_next_s  = NONE;
                    valid_next_s = 1'b0;
                end
            end
            HOLD: begin
                if (coin_ready) begin
                    code_next_s  = NONE;
                    valid_next_s = 1'b0;
                    state_next_s = RELEASE;
                end else begin
                    valid_next_s = 1'b1;
                end
            end
            RELEASE: begin
                code_next_s  = NONE;
                valid_next_s = 1'b0;
                if (stable_s == 3'b000) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RELEASE;
                end
            end
            default: begin
                code_next_s  = NONE;
                valid_next_s = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy tracks the registered state.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_r  <= IDLE;
            code_r   <= NONE;
            valid_r  <= 1'b0;
            reject_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            code_r   <= code_next_s;
            valid_r  <= valid_next_s;
            reject_r <= reject_next_s;
            busy_r   <= (state_next_s != IDLE);
        end
    end

    assign coin_code   = code_r;
    assign coin_valid  = valid_r;
    assign coin_reject = reject_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a short debounce window; a negedge
// monitor counts handshakes, rejects and hold-stability violations.
module tb_coin_acceptor;

    localparam int unsigned D = 8;

    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic       q = 1'b0;
    logic       h = 1'b0;
    logic       d = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] coin_code;
    logic       coin_valid;
    logic       coin_reject;
    logic       busy;

    int         total_cnt = 0;
    int         bad_cnt = 0;
    int         hs_cnt = 0;
    int         rej_cnt = 0;
    int         val_cyc = 0;
    int         stab_err = 0;
    logic [1:0] last_code = 2'b00;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [1:0] pc = 2'b00;
    int         hs0, rej0, val0, stab0;

    coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .quarter_in   (q),
        .halfDollar_in(h),
        .dollar_in    (d),
        .coin_ready   (ready),
        .coin_code    (coin_code),
        .coin_valid   (coin_valid),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Sampled mid-cycle: what is seen here is what the next posedge acts on.
    always @(negedge CLK) begin
        if (!RES) begin
            pv <= 1'b0;
            pr <= 1'b0;
            pc <= 2'b00;
        end else begin
            if (coin_valid && ready) begin
                hs_cnt    <= hs_cnt + 1;
                last_code <= coin_code;
            end
            if (coin_reject) rej_cnt <= rej_cnt + 1;
            if (coin_valid) val_cyc <= val_cyc + 1;
            if ((pv && !pr && (!coin_valid || coin_code !== pc)) || (pv && pr && coin_valid))
                stab_err <= stab_err + 1;
            pv <= coin_valid;
            pr <= ready;
            pc <= coin_code;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (coin_valid) seen = 1'b1;
        end
        check_val(tag, seen, 1);
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 80 && !idle; i++) begin
            tick();
            if (!busy) idle = 1'b1;
        end
        check_val(tag, idle, 1);
        ticks(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks(3);
        check_val("rst_valid", coin_valid, 0);
        check_val("rst_code", coin_code, 0);
        check_val("rst_reject", coin_reject, 0);
        check_val("rst_busy", busy, 0);
        RES = 1'b1;
        ticks(2);

        // 1: clean quarter, ready tied high, valid exactly on cycle 11
        hs0 = hs_cnt; val0 = val_cyc;
        ready = 1'b1;
        q = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            check_val("t1_valid", coin_valid, (n == 11));
            if (n == 11) check_val("t1_code", coin_code, 1);
        end
        ticks(6);
        q = 1'b0;
        wait_idle("t1_idle");
        check_val("t1_hs", hs_cnt - hs0, 1);
        check_val("t1_vcyc", val_cyc - val0, 1);

        // 2: dollar with ready held low for 50 cycles
        hs0 = hs_cnt; stab0 = stab_err;
        ready = 1'b0;
        d = 1'b1;
        wait_valid("t2_seen");
        check_val("t2_code0", coin_code, 3);
        ticks(50);
        check_val("t2_hold_valid", coin_valid, 1);
        check_val("t2_hold_code", coin_code, 3);
        check_val("t2_no_hs", hs_cnt - hs0, 0);
        ready = 1'b1;
        ticks(2);
        check_val("t2_drop_valid", coin_valid, 0);
        check_val("t2_drop_code", coin_code, 0);
        check_val("t2_hs", hs_cnt - hs0, 1);
        check_val("t2_stable", stab_err - stab0, 0);
        d = 1'b0;
        wait_idle("t2_idle");

        // 3: bouncing half dollar, then steady
        hs0 = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            h = ~h;
            ticks(3);
        end
        h = 1'b1;
        ticks(30);
        check_val("t3_hs", hs_cnt - hs0, 1);
        check_val("t3_code", last_code, 2);
        h = 1'b0;
        wait_idle("t3_idle");
        check_val("t3_once", hs_cnt - hs0, 1);

        // 4: quarter and dollar together -> reject, then a half dollar
        hs0 = hs_cnt; rej0 = rej_cnt; val0 = val_cyc;
        q = 1'b1;
        d = 1'b1;
        ticks(20);
        check_val("t4_reject", rej_cnt - rej0, 1);
        check_val("t4_no_valid", val_cyc - val0, 0);
        check_val("t4_busy", busy, 1);
        q = 1'b0;
        d = 1'b0;
        wait_idle("t4_idle");
        h = 1'b1;
        ticks(20);
        check_val("t4_hs", hs_cnt - hs0, 1);
        check_val("t4_code", last_code, 2);
        h = 1'b0;
        wait_idle("t4_idle2");

        // 5: quarter held long, half dollar pressed during HOLD
        hs0 = hs_cnt;
        ready = 1'b0;
        q = 1'b1;
        wait_valid("t5_seen");
        h = 1'b1;
        ticks(20);
        check_val("t5_hold_code", coin_code, 1);
        ready = 1'b1;
        ticks(69);
        check_val("t5_hs", hs_cnt - hs0, 1);
        check_val("t5_code", last_code, 1);
        q = 1'b0;
        ticks(20);
        check_val("t5_busy", busy, 1);
        h = 1'b0;
        wait_idle("t5_idle");
        check_val("t5_once", hs_cnt - hs0, 1);

        // 6: asynchronous reset while in HOLD
        hs0 = hs_cnt;
        ready = 1'b0;
        d = 1'b1;
        wait_valid("t6_seen");
        #1;
        RES = 1'b0;
        #1;
        check_val("t6_valid", coin_valid, 0);
        check_val("t6_code", coin_code, 0);
        check_val("t6_busy", busy, 0);
        check_val("t6_reject", coin_reject, 0);
        d = 1'b0;
        ticks(3);
        RES = 1'b1;
        ready = 1'b1;
        ticks(2);
        check_val("t6_post_valid", coin_valid, 0);
        q = 1'b1;
        ticks(20);
        check_val("t6_hs", hs_cnt - hs0, 1);
        check_val("t6_code2", last_code, 1);
        q = 1'b0;
        wait_idle("t6_idle");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
